// File: rtl/tune_sequencer.sv
// Plays a fixed 16-entry tune into the piano: each entry sounds for its beat count, then a short forced hush.
// Start/stop come from debounced pulses; the loop level decides wrap versus finish after entry 15.
`timescale 1ns/1ps
module tune_sequencer #(
  parameter int TICKS_PER_BEAT = 25_000_000,
  parameter int GAP_TICKS      = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       stop,
  input  logic       loop,
  output logic [3:0] note,
  output logic       hush,
  output logic       busy,
  output logic [3:0] idx
);

  localparam int MAX_TICKS = (TICKS_PER_BEAT > GAP_TICKS) ? TICKS_PER_BEAT : GAP_TICKS;
  localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [TW-1:0] BEAT_LAST = TW'(TICKS_PER_BEAT - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SOUND = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    beat_q, beat_d;
  logic [3:0]    note_q, note_d;
  logic          hush_q, hush_d;
  logic          busy_q, busy_d;
  logic          sound_end_s;
  logic          gap_end_s;

  function automatic logic [2:0] entry_beats(input logic [3:0] i);
    return {1'b0, i[1:0]} + 3'd1;
  endfunction

  // Entries 7 and 15 are rests: the only indices whose low three bits are all ones.
  function automatic logic entry_rest(input logic [3:0] i);
    return (i[2:0] == 3'b111);
  endfunction

  assign sound_end_s = (tick_q == BEAT_LAST) && ((beat_q + 3'd1) == entry_beats(idx_q));
  assign gap_end_s   = (tick_q == GAP_LAST);

  // State, index and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      tick_q  <= '0;
      beat_q  <= 3'd0;
      note_q  <= 4'd0;
      hush_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      beat_q  <= beat_d;
      note_q  <= note_d;
      hush_q  <= hush_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, index and counters; stop overrides everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = '0;
    beat_d  = 3'd0;
    if (stop) begin
      state_d = S_IDLE;
      idx_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          idx_d = 4'd0;
          if (play) begin
            state_d = S_SOUND;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SOUND: begin
          if (sound_end_s) begin
            state_d = S_GAP;
          end else if (tick_q == BEAT_LAST) begin
            beat_d = beat_q + 3'd1;
          end else begin
            tick_d = tick_q + TW'(1);
            beat_d = beat_q;
          end
        end
        S_GAP: begin
          if (!gap_end_s) begin
            tick_d = tick_q + TW'(1);
          end else if (idx_q != 4'd15) begin
            state_d = S_SOUND;
            idx_d   = idx_q + 4'd1;
          end else if (loop) begin
            state_d = S_SOUND;
            idx_d   = 4'd0;
          end else begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 4'd0;
        end
      endcase
    end
  end

  // Output values are derived from the upcoming state so they change on the same edge as it.
  always_comb begin
    note_d = 4'd0;
    hush_d = 1'b1;
    busy_d = 1'b0;
    case (state_d)
      S_IDLE: begin
        note_d = 4'd0;
        hush_d = 1'b1;
        busy_d = 1'b0;
      end
      S_SOUND: begin
        note_d = idx_d;
        hush_d = entry_rest(idx_d);
        busy_d = 1'b1;
      end
      S_GAP: begin
        note_d = note_q;
        hush_d = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        note_d = 4'd0;
        hush_d = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign note = note_q;
  assign hush = hush_q;
  assign busy = busy_q;
  assign idx  = idx_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Self-checking bench for tune_sequencer: a timeline model of the tune plus directed literal checks.
`timescale 1ns/1ps
module tb_tune_sequencer;

  localparam int TPB  = 10;
  localparam int GAP  = 2;
  localparam int PASS = 40 * TPB + 16 * GAP;

  logic       clk;
  logic       rst;
  logic       play;
  logic       stop;
  logic       loop;
  logic [3:0] note;
  logic       hush;
  logic       busy;
  logic [3:0] idx;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  bit check_en = 1'b0;

  bit m_busy = 1'b0;
  int m_t    = 0;

  tune_sequencer #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(GAP)) dut (
    .clk  (clk),
    .rst  (rst),
    .play (play),
    .stop (stop),
    .loop (loop),
    .note (note),
    .hush (hush),
    .busy (busy),
    .idx  (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Expected {note, hush, busy, idx} given whether a pass is running and edges elapsed since its start.
  function automatic logic [9:0] model_out(input bit act, input int t);
    int r;
    int len;
    r = t;
    if (!act) return {4'd0, 1'b1, 1'b0, 4'd0};
    for (int i = 0; i < 16; i++) begin
      len = ((i % 4) + 1) * TPB;
      if (r < len) return {4'(i), ((i == 7) || (i == 15)) ? 1'b1 : 1'b0, 1'b1, 4'(i)};
      r -= len;
      if (r < GAP) return {4'(i), 1'b1, 1'b1, 4'(i)};
      r -= GAP;
    end
    return 10'h3FF;
  endfunction

  // Model: a pass is just an elapsed-edge count; loop is consulted only when a pass completes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_t    <= 0;
    end else if (stop) begin
      m_busy <= 1'b0;
      m_t    <= 0;
    end else if (!m_busy) begin
      if (play) begin
        m_busy <= 1'b1;
        m_t    <= 0;
      end
    end else if (m_t == PASS - 1) begin
      m_t <= 0;
      if (!loop) m_busy <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic [9:0] e;
    if (check_en) begin
      e = model_out(m_busy, m_t);
      chk("cyc_note", int'(note), int'(e[9:6]));
      chk("cyc_hush", int'(hush), int'(e[5]));
      chk("cyc_busy", int'(busy), int'(e[4]));
      chk("cyc_idx",  int'(idx),  int'(e[3:0]));
    end
  end

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic pulse_play();
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    n = 0;
  endtask

  task automatic finish_wait(input string name, input int exp_len);
    while (busy && (n < exp_len + 50)) step();
    chk(name, n, exp_len);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_note"}, int'(note), 0);
    chk({tag, "_hush"}, int'(hush), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_idx"},  int'(idx),  0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; play = 1'b0; stop = 1'b0; loop = 1'b0;
    #2 rst = 1'b1;
    #1 chk_idle("rst_async");
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    repeat (100) step();
    chk_idle("idle_hold");

    // Single pass, with loop wiggled away from the decision edge.
    loop = 1'b0;
    pulse_play();
    chk("start_busy", int'(busy), 1);
    chk("start_hush", int'(hush), 0);
    chk("start_note", int'(note), 0);
    run_to(9);   chk("e0_last_hush", int'(hush), 0);
    run_to(10);  chk("e0_gap_hush", int'(hush), 1); chk("e0_gap_note", int'(note), 0);
    run_to(12);  chk("e1_idx", int'(idx), 1); chk("e1_hush", int'(hush), 0);
    run_to(66);  chk("e3_idx", int'(idx), 3); chk("e3_first_hush", int'(hush), 0);
    run_to(105); chk("e3_last_hush", int'(hush), 0);
    run_to(106); chk("e3_gap_hush", int'(hush), 1);
    run_to(180); chk("e7_rest_hush", int'(hush), 1); chk("e7_note", int'(note), 7);
    run_to(200); loop = 1'b1;
    run_to(300); loop = 1'b0;
    finish_wait("single_len", PASS);

    // Looping pass, then drop loop for the second.
    repeat (3) step();
    loop = 1'b1;
    pulse_play();
    run_to(PASS); chk("wrap_idx", int'(idx), 0); chk("wrap_hush", int'(hush), 0); chk("wrap_busy", int'(busy), 1);
    run_to(440);  loop = 1'b0;
    finish_wait("loop_len", 2 * PASS);

    // Stop during entry 5, then play+stop together in idle.
    repeat (3) step();
    pulse_play();
    run_to(125); chk("e5_idx", int'(idx), 5);
    stop = 1'b1; step(); stop = 1'b0;
    chk_idle("stop");
    play = 1'b1; stop = 1'b1; step(); play = 1'b0; stop = 1'b0;
    chk("prio_busy", int'(busy), 0);
    step(); chk("prio_busy2", int'(busy), 0);

    // Play while busy is ignored.
    pulse_play();
    run_to(35); play = 1'b1; step(); play = 1'b0;
    chk("busy_play_idx", int'(idx), 2);
    finish_wait("busy_play_len", PASS);

    // Async reset during entry 9's gap, then a clean restart.
    repeat (3) step();
    pulse_play();
    run_to(248); chk("e9_gap_idx", int'(idx), 9); chk("e9_gap_hush", int'(hush), 1);
    #2 rst = 1'b1;
    #1 chk_idle("rst_gap");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    pulse_play();
    run_to(9);  chk("re_e0_hush", int'(hush), 0); chk("re_e0_idx", int'(idx), 0);
    run_to(10); chk("re_e0_gap", int'(hush), 1);
    finish_wait("restart_len", PASS);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
